// File: rtl/cordic_rr_sched.sv
// cordic_rr_sched: round-robin front end that shares one iterative CORDIC
// core between four requesters. One job at a time: grant, start the core,
// wait for a fresh done, deliver the result with a one-cycle ack.
//
// Handshake: a requester holds req[k] high until it sees ack[k]. ack[k] is a
// single-cycle pulse, and cos_out/sin_out are valid only in that cycle.
// Towards the core, core_start is a one-cycle pulse. core_done stays high
// after completion until the next start, so the first done seen after a start
// is treated as stale until core_done has been observed low.
module cordic_rr_sched #(
    parameter int TIMEOUT = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [35:0] z_in,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [10:0] cos_out,
    output logic [10:0] sin_out,
    output logic        err,
    output logic        core_start,
    output logic [8:0]  core_z0,
    input  logic [10:0] core_cos,
    input  logic [10:0] core_sin,
    input  logic        core_done,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [1:0]  last_q, last_d;
    logic [8:0]  angle_q, angle_d;
    logic [10:0] cos_q, cos_d;
    logic [10:0] sin_q, sin_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [8:0]  z_arr [4];
    logic        sel_found;
    logic [1:0]  sel_idx;
    logic [1:0]  cand;
    logic        cnt_expired;

    // Split the packed angle bus into one 9-bit angle per requester.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            z_arr[k] = z_in[9*k +: 9];
        end
    end

    // Round-robin pick: first active request starting after the last served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign cnt_expired = (cnt_q == CW'(TIMEOUT));

    // Next-state logic for the job sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        angle_d = angle_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_found) begin
                    gnt_d   = 4'b0001 << sel_idx;
                    gidx_d  = sel_idx;
                    angle_d = z_arr[sel_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A done still high from the previous job is ignored here.
                if (cnt_expired) begin
                    err_d   = 1'b1;
                    cos_d   = '0;
                    sin_d   = '0;
                    state_d = DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!core_done) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // A real completion wins over a simultaneous timeout.
                if (core_done) begin
                    cos_d   = core_cos;
                    sin_d   = core_sin;
                    state_d = DELIVER;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    cos_d   = '0;
                    sin_d   = '0;
                    state_d = DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DELIVER: begin
                // No grant this cycle; arbitration resumes from IDLE.
                last_d  = gidx_q;
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= 2'd3;
            angle_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            angle_q <= angle_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign ack        = (state_q == DELIVER) ? gnt_q : 4'b0000;
    assign cos_out    = cos_q;
    assign sin_out    = sin_q;
    assign err        = err_q;
    assign core_start = (state_q == ISSUE);
    assign core_z0    = angle_q;
    assign dbg_state  = state_q;

endmodule
